// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_core transmitter among NUM_REQ byte requesters.
// Latency: valid seen in IDLE at cycle t -> req_ready_o at t+1 -> next2tx_o at t+2; one byte in flight.
// Backpressure: req_ready_o pulses only in ISSUE; requesters hold valid until accepted. Define
// UART_TX_ARB_LOCK_EN to hold the grant for a whole packet (released by a byte with req_last_i set).
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BUSY_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             data2tx_o,
    output logic                   next2tx_o,
    input  logic                   tx_busy_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   active_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef UART_TX_ARB_LOCK_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_LOCKED
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [7:0]           data_q, data_d;
    logic                 next_q, next_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 found;
    logic [IW-1:0]        pick;
    logic [IW-1:0]        cand_idx;
    int                   cand;

`ifdef UART_TX_ARB_LOCK_EN
    logic                 last_q, last_d;
`else
    // Packet boundaries only matter when the grant is locked per packet.
    logic                 unused_last;
    assign unused_last = ^req_last_i;
`endif

    // Round-robin search: first valid requester above the last-grant pointer, wrapping.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr_q) + k) % NUM_REQ;
            cand_idx = IW'(cand);
            if (!found && req_valid_i[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
    end

    // State register and datapath flops; synchronous reset aborts whatever is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            data_q  <= '0;
            next_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            next_q  <= next_d;
            cnt_q   <= cnt_d;
`ifdef UART_TX_ARB_LOCK_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next-state and datapath updates; next2tx is a one-cycle pulse so it defaults low.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        next_d  = 1'b0;
        cnt_d   = cnt_q;
`ifdef UART_TX_ARB_LOCK_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gidx_d  = pick;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_valid_i[gidx_q]) begin
                    data_d  = req_data_i[{gidx_q, 3'b000} +: 8];
                    next_d  = 1'b1;
                    cnt_d   = '0;
`ifdef UART_TX_ARB_LOCK_EN
                    last_d  = req_last_i[gidx_q];
`endif
                    state_d = S_WAIT_BUSY;
                end else begin
                    // Requester dropped valid: abandon the grant without moving the pointer.
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_BUSY: begin
                cnt_d = cnt_q + 4'd1;
                // The timeout keeps a transmitter that never reports busy from hanging us.
                if (tx_busy_i || (cnt_d == 4'(BUSY_WAIT))) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy_i) begin
`ifdef UART_TX_ARB_LOCK_EN
                    if (!last_q) begin
                        state_d = S_LOCKED;
                    end else begin
                        ptr_d   = gidx_q;
                        grant_d = '0;
                        state_d = S_IDLE;
                    end
`else
                    ptr_d   = gidx_q;
                    grant_d = '0;
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef UART_TX_ARB_LOCK_EN
            S_LOCKED: begin
                if (req_valid_i[gidx_q]) begin
                    state_d = S_ISSUE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs: ready strobe only for the owner during ISSUE; the rest come straight from flops.
    always_comb begin
        req_ready_o = '0;
        if (state_q == S_ISSUE) begin
            req_ready_o[gidx_q] = 1'b1;
        end
    end

    assign data2tx_o = data_q;
    assign next2tx_o = next_q;
    assign grant_o   = grant_q;
    assign active_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed steps, scoreboard of expected strobes, uart_core busy model.
// Strobes are checked in order against the queue as they appear on next2tx_o.
// Summary line reports failures against total comparisons.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_last_i;
    logic [3:0]  req_ready_o;
    logic [7:0]  data2tx_o;
    logic        next2tx_o;
    logic        tx_busy_i;
    logic [3:0]  grant_o;
    logic        active_o;

    uart_tx_arbiter #(.NUM_REQ(4), .BUSY_WAIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .data2tx_o   (data2tx_o),
        .next2tx_o   (next2tx_o),
        .tx_busy_i   (tx_busy_i),
        .grant_o     (grant_o),
        .active_o    (active_o)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] grant;
    } exp_t;

    exp_t sb[$];
    int   strobe_cyc[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_strobe = 0;
    int   cyc      = 0;
    int   busy_len = 0;
    int   busy_left = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] g);
        exp_t e;
        e.data  = d;
        e.grant = g;
        sb.push_back(e);
    endtask

    // uart_core busy model: busy rises the cycle after a strobe and stays high busy_len cycles.
    initial begin
        tx_busy_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) busy_left = 0;
            if (busy_left > 0) begin
                tx_busy_i = 1'b1;
                busy_left--;
            end else begin
                tx_busy_i = 1'b0;
            end
            if (next2tx_o && busy_len > 0) busy_left = busy_len;
        end
    end

    // Strobe monitor: every next2tx_o pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && next2tx_o) begin
                n_strobe++;
                strobe_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_data", 32'(data2tx_o), 32'(e.data));
                    chk("strobe_grant", 32'(grant_o), 32'(e.grant));
                end
            end
        end
    end

    task automatic do_reset();
        rst         = 1'b1;
        req_valid_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_strobes(input string tag, input int target, input int limit);
        for (int i = 0; i < limit && n_strobe < target; i++) @(negedge clk);
        chk(tag, 32'(n_strobe), 32'(target));
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int i = 0; i < limit && active_o; i++) @(negedge clk);
        chk(tag, 32'(active_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   s0;
        int   a;
        int   b;
        bit   saw_busy;
        logic acc1;
        int   idx1;
        int   target;
        logic [7:0] b1 [3];

        rst         = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  32'(req_ready_o), 32'd0);
        chk("rst_data",   32'(data2tx_o),   32'd0);
        chk("rst_next",   32'(next2tx_o),   32'd0);
        chk("rst_grant",  32'(grant_o),     32'd0);
        chk("rst_active", 32'(active_o),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte from requester 0 with a 10-cycle busy period
        busy_len = 10;
        @(posedge clk);
        #1;
        req_valid_i = 4'b0001;
        req_data_i  = 32'h0000_0041;
        push(8'h41, 4'b0001);
        base = n_strobe;
        @(negedge clk);
        chk("t1_idle_ready",  32'(req_ready_o), 32'd0);
        chk("t1_idle_active", 32'(active_o),    32'd0);
        @(negedge clk);
        chk("t1_issue_ready", 32'(req_ready_o), 32'b0001);
        chk("t1_issue_grant", 32'(grant_o),     32'b0001);
        chk("t1_issue_next",  32'(next2tx_o),   32'd0);
        chk("t1_issue_active", 32'(active_o),   32'd1);
        @(posedge clk);
        #1;
        req_valid_i = '0;
        @(negedge clk);
        chk("t1_strobe_next",  32'(next2tx_o),   32'd1);
        chk("t1_strobe_ready", 32'(req_ready_o), 32'd0);
        a = -1;
        b = -1;
        saw_busy = 1'b0;
        for (int i = 0; i < 40 && a < 0; i++) begin
            @(negedge clk);
            if (b < 0 && saw_busy && !tx_busy_i) b = cyc;
            if (tx_busy_i) saw_busy = 1'b1;
            if (!active_o) a = cyc;
        end
        chk("t1_active_fall_delay", 32'(a - b), 32'd1);
        chk("t1_strobe_count", 32'(n_strobe - base), 32'd1);
        chk("t1_data_hold", 32'(data2tx_o), 32'h41);

        // All four requesters valid: strict rotation starting at 0
        do_reset();
        busy_len = 3;
        req_data_i  = 32'h4030_2010;
        req_valid_i = 4'b1111;
        push(8'h10, 4'b0001);
        push(8'h20, 4'b0010);
        push(8'h30, 4'b0100);
        push(8'h40, 4'b1000);
        push(8'h10, 4'b0001);
        target = n_strobe + 5;
        wait_strobes("t2_strobes", target, 200);
        @(posedge clk);
        #1;
        req_valid_i = '0;
        wait_idle("t2_idle", 60);
        chk("t2_no_extra", 32'(n_strobe), 32'(target));

        // Transmitter never reports busy: timeout paces strobes 7 cycles apart
        do_reset();
        busy_len = 0;
        req_data_i  = 32'h0055_0000;
        req_valid_i = 4'b0100;
        push(8'h55, 4'b0100);
        push(8'h55, 4'b0100);
        push(8'h55, 4'b0100);
        s0 = strobe_cyc.size();
        target = n_strobe + 3;
        wait_strobes("t3_strobes", target, 100);
        @(posedge clk);
        #1;
        req_valid_i = '0;
        wait_idle("t3_idle", 30);
        if (strobe_cyc.size() >= s0 + 3) begin
            chk("t3_gap1", 32'(strobe_cyc[s0+1] - strobe_cyc[s0]),   32'd7);
            chk("t3_gap2", 32'(strobe_cyc[s0+2] - strobe_cyc[s0+1]), 32'd7);
        end else begin
            chk("t3_gap_samples", 32'(strobe_cyc.size()), 32'(s0 + 3));
        end

        // Reset during WAIT_DONE, then priority restarts at requester 0
        busy_len = 10;
        @(posedge clk);
        #1;
        req_data_i  = 32'h7700_0000;
        req_valid_i = 4'b1000;
        push(8'h77, 4'b1000);
        target = n_strobe + 1;
        wait_strobes("t4_first_strobe", target, 40);
        @(posedge clk);
        #1;
        req_valid_i = '0;
        repeat (2) @(negedge clk);
        chk("t4_busy_active", 32'(active_o), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_data_i  = 32'h0403_0201;
        req_valid_i = 4'b1111;
        push(8'h01, 4'b0001);
        @(negedge clk);
        chk("t4_rst_active", 32'(active_o),    32'd0);
        chk("t4_rst_grant",  32'(grant_o),     32'd0);
        chk("t4_rst_next",   32'(next2tx_o),   32'd0);
        chk("t4_rst_data",   32'(data2tx_o),   32'd0);
        chk("t4_rst_ready",  32'(req_ready_o), 32'd0);
        target = n_strobe + 1;
        wait_strobes("t4_after_rst_strobe", target, 40);
        @(posedge clk);
        #1;
        req_valid_i = '0;
        wait_idle("t4_idle", 60);

        // Packet of three bytes from requester 1 against a continuously valid requester 0
        do_reset();
        busy_len = 2;
        b1[0] = 8'hB1;
        b1[1] = 8'hB2;
        b1[2] = 8'hB3;
        idx1 = 0;
        req_data_i  = {16'h0000, b1[0], 8'hA0};
        req_last_i  = 4'b0001;
        req_valid_i = 4'b0011;
`ifdef UART_TX_ARB_LOCK_EN
        push(8'hA0, 4'b0001);
        push(8'hB1, 4'b0010);
        push(8'hB2, 4'b0010);
        push(8'hB3, 4'b0010);
        push(8'hA0, 4'b0001);
        target = n_strobe + 5;
`else
        push(8'hA0, 4'b0001);
        push(8'hB1, 4'b0010);
        push(8'hA0, 4'b0001);
        push(8'hB2, 4'b0010);
        push(8'hA0, 4'b0001);
        push(8'hB3, 4'b0010);
        target = n_strobe + 6;
`endif
        for (int i = 0; i < 400 && n_strobe < target; i++) begin
            @(negedge clk);
            acc1 = req_valid_i[1] & req_ready_o[1];
            @(posedge clk);
            #1;
            if (acc1) begin
                idx1++;
                if (idx1 >= 3) begin
                    req_valid_i[1] = 1'b0;
                end else begin
                    req_data_i[15:8] = b1[idx1];
                    req_last_i[1]    = (idx1 == 2);
                end
            end
        end
        req_valid_i = '0;
        chk("t5_strobes", 32'(n_strobe), 32'(target));
        wait_idle("t5_idle", 60);
        chk("t5_bytes_taken", 32'(idx1), 32'd3);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_core transmitter among NUM_REQ byte-stream requesters, for example a command responder, a debug printer and a status reporter.
- Selects requesters round-robin and drives the core's data2tx_i/next2tx_i pair.
- Paces each byte using the core's tx_busy_o.
- Sits between the requester logic and uart_core, in the same clock domain.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- BUSY_WAIT, 4: maximum cycles to wait for tx_busy_i to rise after a next2tx_o pulse; legal range 1..15.

Ports:
- clk  in  1  global clock
- rst  in  1  global reset, synchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester byte valid; must be held until accepted
- req_data_i  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i]
- req_last_i  in  NUM_REQ  per-requester last-byte-of-packet flag; used only with UART_TX_ARB_LOCK_EN
- req_ready_o  out  NUM_REQ  per-requester accept strobe; a byte transfers when valid and ready are both high
- data2tx_o  out  8  byte to uart_core data2tx_i
- next2tx_o  out  1  one-cycle strobe to uart_core next2tx_i
- tx_busy_i  in  1  from uart_core tx_busy_o
- grant_o  out  NUM_REQ  one-hot current owner; zero when idle
- active_o  out  1  high whenever the state is not IDLE

Behaviour:
- Reset values: every output is 0, state is IDLE, and the last-grant pointer is NUM_REQ-1, so requester 0 has highest priority after reset.
- A synchronous rst aborts any state in the next cycle. A byte already handed to uart_core completes on the line; the arbiter does not track it.
- IDLE:
  - If any req_valid_i bit is high, pick the first set bit searching upward from pointer+1, modulo NUM_REQ.
  - Register that choice into grant_o and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - req_ready_o[g] = 1, combinational from state and grant; all other req_ready_o bits stay 0.
  - If req_valid_i[g] is high, on the clock edge: load data2tx_o from requester g, set next2tx_o for one cycle, capture req_last_i[g], clear the busy-wait counter, and go to WAIT_BUSY.
  - If req_valid_i[g] is low (protocol violation), return to IDLE, leave the pointer unchanged, clear grant_o and send no strobe.
- WAIT_BUSY:
  - next2tx_o is high in the first cycle of this state only.
  - The counter increments each cycle.
  - Go to WAIT_DONE when tx_busy_i = 1, or when the counter reaches BUSY_WAIT. The timeout covers a transmitter that never reports busy.
- WAIT_DONE:
  - Wait while tx_busy_i = 1.
  - When tx_busy_i = 0: set pointer = g, clear grant_o and go to IDLE (base behaviour).
- Latency: valid sampled in IDLE at cycle t gives ISSUE at t+1 and next2tx_o high at t+2.
- Minimum spacing between two next2tx_o pulses is one full transmitter busy period plus 3 cycles.
- data2tx_o holds its value until the next ISSUE transfer.
- Simultaneous valid from all requesters is served in strict rotation: 0,1,2,3,0,...
- A requester whose valid rises while another requester is served waits for its turn; it is never starved beyond NUM_REQ-1 bytes (base mode).

Optional Feature:
- Macro UART_TX_ARB_LOCK_EN.
- With the macro defined, the grant is held for a whole packet:
  - In WAIT_DONE, when tx_busy_i falls and the captured last flag is 0, go to a LOCKED state instead of IDLE. grant_o stays set and the pointer is not updated.
  - LOCKED goes to ISSUE when req_valid_i[g] = 1 and ignores all other requesters.
  - The pointer updates only after a byte with req_last_i = 1 completes.
  - rst releases the lock.
- Without the macro:
  - req_last_i is unused.
  - The grant rotates after every byte.
  - No LOCKED state exists.

Test Plan:
- After rst, req_valid_i=4'b0001 with byte 0x41 and tx_busy_i modelled high for 10 cycles starting 1 cycle after the strobe: next2tx_o pulses exactly once, 2 cycles after valid; data2tx_o=0x41; req_ready_o=4'b0001 for one cycle; active_o falls 1 cycle after busy falls.
- All four valid, bytes 0x10/0x20/0x30/0x40 held: strobe order 0x10,0x20,0x30,0x40,0x10; grant_o sequence 0001,0010,0100,1000,0001.
- tx_busy_i tied 0, BUSY_WAIT=4: each byte completes after the 4-cycle timeout; strobes are 7 cycles apart; no hang.
- rst asserted during WAIT_DONE: next cycle all outputs are 0 and state is IDLE; the following request is served by priority from requester 0.
- LOCK_EN: requester 1 sends a 3-byte packet (last on byte 3) while requester 0 is continuously valid; the three strobes for requester 1 are contiguous and requester 0 is served next. Without the macro, requesters 0 and 1 alternate.
